// File: rtl/interconexion_pkg.sv
// Shared sizing for the interconnect buffers and the control FSM.
// Also holds the decoded access type used by fifo_umbral.
package interconexion_pkg;

  localparam int DATA_WIDTH_DEF = 6;

  // Umbral widths shared with the control FSM; each equals the FIFO's pointer width.
  localparam int MF_SIZE = 3;
  localparam int VC_SIZE = 3;
  localparam int D_SIZE  = 3;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  localparam int DEPTH_DEF = fifo_depth(MF_SIZE);

  typedef struct packed {
    logic wr;   // write accepted
    logic rd;   // read accepted
    logic ovf;  // write rejected because full
    logic udf;  // read rejected because empty
  } access_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH dual-port storage with one write port and a registered read port.
// rd_data holds its value when no read is requested.
module fifo_mem
  import interconexion_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = MF_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; the pointers and count define which words are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // A simultaneous write to rd_addr is not visible here: the read returns the old word.
  always_ff @(posedge clk) begin
    if (!reset)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds
// and a one-cycle, non-sticky error pulse per overflow or underflow.
module fifo_umbral
  import interconexion_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = MF_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] full_umbral,
  input  logic [ADDR_WIDTH-1:0] empty_umbral,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty_sig,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  err_sig
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  access_t               acc;

  assign full         = (count == DEPTH_CNT);
  assign empty_sig    = (count == '0);
  assign almost_full  = (count >= {1'b0, full_umbral});
  assign almost_empty = (count <= {1'b0, empty_umbral});

  // At full a paired read frees the slot the write lands in, so both proceed.
  always_comb begin
    acc     = '0;
    acc.wr  = wr_en & (~full | rd_en);
    acc.rd  = rd_en & ~empty_sig;
    acc.ovf = wr_en & full & ~rd_en;
    acc.udf = rd_en & empty_sig;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_out <= 1'b0;
      err_sig   <= 1'b0;
    end else begin
      if (acc.wr) wr_ptr <= wr_ptr + 1'b1;
      if (acc.rd) rd_ptr <= rd_ptr + 1'b1;
      case ({acc.wr, acc.rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      valid_out <= acc.rd;
      err_sig   <= acc.ovf | acc.udf;
    end
  end

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (acc.wr & reset),
    .wr_addr(wr_ptr),
    .wr_data(data_in),
    .rd_en  (acc.rd & reset),
    .rd_addr(rd_ptr),
    .rd_data(data_out)
  );

endmodule

// File: tb/tb_fifo_umbral.sv
// Self-checking bench for fifo_umbral: a queue scoreboard of written words,
// popped when a read is accepted and compared against data_out one cycle later.
module tb_fifo_umbral;
  import interconexion_pkg::*;

  localparam int DW    = 6;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en, rd_en;
  logic [DW-1:0] data_in;
  logic [AW-1:0] full_umbral, empty_umbral;
  logic [DW-1:0] data_out;
  logic          valid_out, full, empty_sig, almost_full, almost_empty, err_sig;

  fifo_umbral #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .rd_en       (rd_en),
    .full_umbral (full_umbral),
    .empty_umbral(empty_umbral),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .full        (full),
    .empty_sig   (empty_sig),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .err_sig     (err_sig)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] sb [$];
  logic          exp_valid = 1'b0;
  logic          exp_err   = 1'b0;
  logic [DW-1:0] exp_data  = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic check_flags(input string tag);
    int n;
    n = sb.size();
    check({tag, ".empty"},        32'(empty_sig),    32'(n == 0));
    check({tag, ".full"},         32'(full),         32'(n == DEPTH));
    check({tag, ".almost_full"},  32'(almost_full),  32'(n >= int'(full_umbral)));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= int'(empty_umbral)));
  endtask

  // Drive one cycle, update the scoreboard from pre-edge occupancy, then check after the edge.
  task automatic step(input logic rst_v, input logic wr, input logic [DW-1:0] d,
                      input logic rd, input string tag);
    logic is_full, is_empty;
    reset = rst_v; wr_en = wr; data_in = d; rd_en = rd;
    if (!rst_v) begin
      sb.delete();
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      exp_data  = '0;
    end else begin
      is_full   = (sb.size() == DEPTH);
      is_empty  = (sb.size() == 0);
      exp_err   = (wr && is_full && !rd) || (rd && is_empty);
      exp_valid = rd && !is_empty;
      if (exp_valid) exp_data = sb.pop_front();
      if (wr && (!is_full || rd)) sb.push_back(d);
    end
    @(posedge clk);
    #1;
    check({tag, ".valid"}, 32'(valid_out), 32'(exp_valid));
    check({tag, ".data"},  32'(data_out),  32'(exp_data));
    check({tag, ".err"},   32'(err_sig),   32'(exp_err));
    check_flags(tag);
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    full_umbral = 3'd6; empty_umbral = 3'd2;

    // Reset held with both requests active
    step(1'b0, 1'b1, 6'h11, 1'b1, "rst0");
    step(1'b0, 1'b1, 6'h12, 1'b1, "rst1");

    // Fill: almost_empty drops after 3rd, almost_full rises after 6th, full after 8th
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b1, 6'(i), 1'b0, $sformatf("fill%0d", i));

    // Overflow twice, then idle clears err_sig
    step(1'b1, 1'b1, 6'h3F, 1'b0, "ovf0");
    step(1'b1, 1'b1, 6'h3E, 1'b0, "ovf1");
    step(1'b1, 1'b0, 6'h00, 1'b0, "ovf_clr");

    // Simultaneous access at full, wrapping the pointers
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 6'(6'h20 + i), 1'b1, $sformatf("wrap%0d", i));

    // Drain
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 6'h00, 1'b1, $sformatf("drain%0d", i));
    step(1'b1, 1'b0, 6'h00, 1'b0, "drain_idle");

    // Underflow with simultaneous write, then read back
    step(1'b1, 1'b1, 6'h2A, 1'b1, "udf_wr");
    step(1'b1, 1'b0, 6'h00, 1'b1, "udf_rd");
    step(1'b1, 1'b0, 6'h00, 1'b1, "udf_empty");

    // Reset mid-stream
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 6'(6'h30 + i), 1'b0, $sformatf("pre_rst%0d", i));
    step(1'b0, 1'b1, 6'h05, 1'b1, "mid_rst");
    step(1'b1, 1'b0, 6'h00, 1'b1, "post_rst_rd");
    step(1'b1, 1'b1, 6'h15, 1'b0, "post_rst_wr");
    step(1'b1, 1'b0, 6'h00, 1'b1, "post_rst_rd2");

    // Umbral extremes act combinationally in the same cycle
    full_umbral = 3'd0; empty_umbral = 3'd7;
    #1 check_flags("umbral_ext_empty");
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 6'(i + 8), 1'b0, $sformatf("ext_fill%0d", i));
    full_umbral = 3'd7; empty_umbral = 3'd0;
    #1 check_flags("umbral_ext_full");

    // Random traffic with occasional resets and umbral changes
    for (int i = 0; i < 300; i++) begin
      if (i % 40 == 0) begin
        full_umbral  = 3'($urandom_range(0, 7));
        empty_umbral = 3'($urandom_range(0, 7));
        #1 check_flags($sformatf("rnd_umb%0d", i));
      end
      step(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
           1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
